alu_issue: RTL
==============

Name: alu_issue

Overview:
- Execute-stage initiator that drives the combinational `alu`.
- Accepts decoded RV32I integer instructions (OP, OP-IMM, LUI, AUIPC) over a valid/ready handshake.
- Maps funct3/funct7 to the 4-bit `alu_op` code, presents `operand_a`/`operand_b` to the ALU, and captures `result` into a backpressurable output register for writeback.
- Two-stage pipeline, one instruction per cycle sustained.

Parameters:
- XLEN, 32, datapath width; must match the ALU (32).
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction present
- in_ready  output  1  block accepts the instruction this cycle
- in_opcode  input  7  instr[6:0]
- in_funct3  input  3  instr[14:12]
- in_funct7  input  7  instr[31:25] (for OP-IMM shifts: imm[11:5])
- in_rs1_data  input  XLEN  rs1 value
- in_rs2_data  input  XLEN  rs2 value
- in_imm  input  XLEN  sign-extended immediate (U-type already shifted left by 12)
- in_pc  input  XLEN  instruction PC
- in_rd  input  RD_W  destination index
- alu_operand_a  output  XLEN  to ALU `operand_a`
- alu_operand_b  output  XLEN  to ALU `operand_b`
- alu_op  output  4  to ALU `alu_op`
- alu_result  input  XLEN  from ALU `result` (combinational)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_result  output  XLEN  registered ALU result
- out_rd  output  RD_W  destination index
- out_illegal  output  1  instruction was not a supported encoding

Behaviour:
- ALU code map (fixed): 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- Decode by funct3 for OP (0110011) and OP-IMM (0010011):
  - 000: ADD; SUB only for OP with funct7=0100000.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL if funct7=0000000; SRA if funct7=0100000.
  - 110: OR.
  - 111: AND.
- Operands:
  - OP: a=rs1, b=rs2.
  - OP-IMM: a=rs1, b=imm.
  - LUI (0110111): a=0, b=imm, ADD.
  - AUIPC (0010111): a=pc, b=imm, ADD.
- Illegal cases, each giving alu_op=0000, a=b=0, illegal flag=1, result 0:
  - any other opcode;
  - OP with funct7 not in {0000000, 0100000}, or 0100000 with funct3 not in {000, 101};
  - SLL/SRL/SRA with funct7 other than the legal value.
- Stage 1 (s1):
  - Registers decoded alu_op, operand_a, operand_b, rd, illegal, plus s1_valid; the ALU ports are driven directly from these registers.
  - Loads only on accept (in_valid & in_ready); otherwise holds.
- Stage 2 (s2):
  - Registers out_result (sampled from alu_result), out_rd, out_illegal, plus out_valid.
  - Loads when s1 advances.
- Flow control:
  - s1 advances when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | s1_advance. Combinational; no combinational path from in_valid to in_ready.
  - out_valid sets on s1 advance. It clears when out_ready & !s1_advance.
- Latency: accept at edge N gives out_valid=1 after edge N+1. Throughput is 1 per cycle with out_ready held high.
- Backpressure: when out_ready=0 and out_valid=1, s2 holds. s1 holds if valid, and in_ready drops once s1 is full. No instruction is dropped or duplicated. out_* stay stable while out_valid & !out_ready.
- Simultaneous events:
  - Output consumed and new s1 advance in the same cycle: s2 reloads, out_valid stays 1.
  - Input accepted while s1 advances: s1 reloads.
- Reset (sync, any time, including mid-stall): all of these clear to 0 — s1_valid, out_valid, out_result, out_rd, out_illegal, alu_op (0000), alu_operand_a, alu_operand_b. In-flight instructions are discarded, and in_ready=1 on the first cycle after reset.
- Arithmetic is the ALU's; this block performs no width changes beyond passing XLEN values.

Test Plan:
1. Back-to-back OP-type ADD 10+5 then SUB 10-5 (funct7=0100000), out_ready=1 -> alu_op 0000 then 0001; out_result 15 then 5 on consecutive cycles, 2 cycles after accept; out_rd matches.
2. OP-IMM SRAI rs1=FFFFFFFF, imm=0x404 (funct7=0100000, shamt 4) -> alu_op 0111, operand_b=0x404, out_result=FFFFFFFF. Same with funct7=0 -> SRLI, out_result=0FFFFFFF.
3. LUI imm=0x12345000 and AUIPC pc=0x100, imm=0x1000 -> operand_a 0 then 0x100; out_result 0x12345000 then 0x1100.
4. out_ready=0 for 4 cycles with 3 instructions offered (OR F0F0|0F0F, AND F0F0&0F0F, SLT 5<10) -> in_ready low after 2 accepts; outputs stable. On release: results FFFF, 0, 1 in order, none lost.
5. Illegal opcode 0x7F and OP funct7=0000001 -> out_illegal=1, out_result=0, alu_op=0000; the following legal XOR FFFF^00FF gives FF00 with out_illegal=0.
6. Assert rst while both stages full and stalled -> next cycle out_valid=0, in_ready=1, alu_op=0000, all outputs 0; the next instruction completes normally.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: two-stage RV32I integer execute front-end that decodes
// OP/OP-IMM/LUI/AUIPC, drives an external combinational ALU and
// registers its result behind a valid/ready output stage.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake
//   in_opcode/funct3/7  instruction fields used for decode
//   in_rs1/rs2_data     register operands
//   in_imm, in_pc       immediate (U-type pre-shifted) and PC
//   in_rd               destination register index
//   alu_operand_a/b     operands to the ALU (straight from s1 regs)
//   alu_op              4-bit ALU function code
//   alu_result          combinational ALU result
//   out_valid/out_ready result handshake
//   out_result/rd       registered result and destination
//   out_illegal         instruction was not a supported encoding
module alu_issue #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RD_W-1:0] in_rd,
    output logic [XLEN-1:0] alu_operand_a,
    output logic [XLEN-1:0] alu_operand_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    // ------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------
    logic            is_op;
    logic            f7_zero;
    logic            f7_alt;
    logic [3:0]      fn_op;
    logic            fn_ok;

    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_ill;

    assign is_op   = (in_opcode == OPC_OP);
    assign f7_zero = (in_funct7 == F7_ZERO);
    assign f7_alt  = (in_funct7 == F7_ALT);

    // funct3 -> ALU code. For OP-IMM, funct7 is immediate bits and
    // only constrains the shift encodings.
    always_comb begin
        fn_op = ALU_ADD;
        fn_ok = 1'b1;
        case (in_funct3)
            3'b000: begin
                fn_op = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
                fn_ok = !is_op || f7_zero || f7_alt;
            end
            3'b001: begin
                fn_op = ALU_SLL;
                fn_ok = f7_zero;
            end
            3'b010: begin
                fn_op = ALU_SLT;
                fn_ok = !is_op || f7_zero;
            end
            3'b011: begin
                fn_op = ALU_SLTU;
                fn_ok = !is_op || f7_zero;
            end
            3'b100: begin
                fn_op = ALU_XOR;
                fn_ok = !is_op || f7_zero;
            end
            3'b101: begin
                fn_op = f7_alt ? ALU_SRA : ALU_SRL;
                fn_ok = f7_zero || f7_alt;
            end
            3'b110: begin
                fn_op = ALU_OR;
                fn_ok = !is_op || f7_zero;
            end
            default: begin
                fn_op = ALU_AND;
                fn_ok = !is_op || f7_zero;
            end
        endcase
    end

    // Operand selection; illegal encodings collapse to ADD 0+0 so
    // the captured result is 0.
    always_comb begin
        dec_op  = ALU_ADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        case (in_opcode)
            OPC_OP: begin
                if (fn_ok) begin
                    dec_op = fn_op;
                    dec_a  = in_rs1_data;
                    dec_b  = in_rs2_data;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (fn_ok) begin
                    dec_op = fn_op;
                    dec_a  = in_rs1_data;
                    dec_b  = in_imm;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_b = in_imm;
            end
            OPC_AUIPC: begin
                dec_a = in_pc;
                dec_b = in_imm;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------
    logic            s1_valid_q;
    logic            s1_valid_d;
    logic            s1_adv;
    logic            accept;

    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [RD_W-1:0] rd_q;
    logic            ill_q;

    logic            out_valid_q;
    logic            out_valid_d;
    logic [XLEN-1:0] res_q;
    logic [RD_W-1:0] out_rd_q;
    logic            out_ill_q;

    // s1 moves forward when the output slot is empty or draining.
    assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------
    // Stage 1: decoded operands feeding the ALU
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            ill_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                op_q  <= dec_op;
                a_q   <= dec_a;
                b_q   <= dec_b;
                rd_q  <= in_rd;
                ill_q <= dec_ill;
            end
        end
    end

    // ------------------------------------------------------------
    // Stage 2: captured ALU result
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            out_rd_q    <= '0;
            out_ill_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_adv) begin
                res_q     <= alu_result;
                out_rd_q  <= rd_q;
                out_ill_q <= ill_q;
            end
        end
    end

    assign alu_op        = op_q;
    assign alu_operand_a = a_q;
    assign alu_operand_b = b_q;
    assign out_valid     = out_valid_q;
    assign out_result    = res_q;
    assign out_rd        = out_rd_q;
    assign out_illegal   = out_ill_q;

endmodule
